// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, default
// timing constants and a counter-width helper.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCK = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    localparam int DEFAULT_GAP_CYCLES = 16;
    localparam int DEFAULT_TIMEOUT    = 1_250_000;

    // One spare bit above the terminal count so a counter can never wrap.
    function automatic int ctr_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first valid index found
// when searching upward from ptr+1, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    logic [IDX_W-1:0] cand [NUM_REQ];

    // cand[k] is the requester examined at search distance k+1 from ptr.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand[gi] = IDX_W'((int'(ptr) + gi + 1) % NUM_REQ);
        end
    endgenerate

    // Walk from farthest to nearest so the nearest valid candidate wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid[cand[k]]) begin
                idx   = cand[k];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters; a grant is held for a
// whole message, followed by an idle gap, with a stall timeout that revokes it.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]           tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_pulse
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int GAP_W   = ctr_width(GAP_CYCLES);
    localparam int TO_W    = ctr_width(TIMEOUT);
    localparam int GAP_MAX = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int TO_MAX  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam arb_state_t END_STATE = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    arb_state_t       state_reg;
    logic [IDX_W-1:0] grant_id_reg;
    logic [IDX_W-1:0] rr_ptr_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic [TO_W-1:0]  to_cnt_reg;
    logic             timeout_pulse_reg;

    logic [WIDTH-1:0] data_arr [NUM_REQ];
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             cur_valid;
    logic             cur_last;
    logic             handshake;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_data
            assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .valid (req_valid),
        .ptr   (rr_ptr_reg),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign cur_valid     = req_valid[grant_id_reg];
    assign cur_last      = req_last[grant_id_reg];
    assign handshake     = (state_reg == ST_LOCK) && cur_valid && tx_ready;
    assign grant_id      = grant_id_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign timeout_pulse = timeout_pulse_reg;

    // The owner's stream passes straight through so the transmitter sees no extra latency.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        if (state_reg == ST_LOCK) begin
            tx_valid                = cur_valid;
            tx_data                 = data_arr[grant_id_reg];
            req_ready[grant_id_reg] = tx_ready;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= ST_IDLE;
            grant_id_reg      <= '0;
            rr_ptr_reg        <= IDX_W'(NUM_REQ - 1);
            gap_cnt_reg       <= '0;
            to_cnt_reg        <= '0;
            timeout_pulse_reg <= 1'b0;
        end else begin
            timeout_pulse_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_id_reg <= pick_idx;
                        rr_ptr_reg   <= pick_idx;
                        to_cnt_reg   <= '0;
                        state_reg    <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (handshake && cur_last) begin
                        to_cnt_reg  <= '0;
                        gap_cnt_reg <= '0;
                        state_reg   <= END_STATE;
                    end else if (cur_valid) begin
                        to_cnt_reg <= '0;
                    end else if (TIMEOUT > 0) begin
                        // Owner stalled mid-message: revoke once the budget is spent.
                        if (to_cnt_reg == TO_W'(TO_MAX)) begin
                            timeout_pulse_reg <= 1'b1;
                            to_cnt_reg        <= '0;
                            gap_cnt_reg       <= '0;
                            state_reg         <= END_STATE;
                        end else begin
                            to_cnt_reg <= to_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg == GAP_W'(GAP_MAX)) begin
                        gap_cnt_reg <= '0;
                        state_reg   <= ST_IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: requesters replay byte buffers and a
// message-level round-robin model predicts the transmitted stream.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 3;
    localparam int WIDTH   = 8;
    localparam int GAP     = 16;
    localparam int TMO     = 10;
    localparam int MAXB    = 64;
    localparam int MAXLOG  = 512;
    localparam int MAXSTEP = 20000;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         tx_data;
    logic                     tx_valid;
    logic                     tx_ready;
    logic [1:0]               grant_id;
    logic                     busy;
    logic                     timeout_pulse;

    uart_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .WIDTH      (WIDTH),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-requester pending bytes; valid is held whenever pos < len.
    logic [7:0] buf_data [NUM_REQ][MAXB];
    bit         buf_last [NUM_REQ][MAXB];
    int         buf_len  [NUM_REQ];
    int         buf_pos  [NUM_REQ];

    int   ready_mode;
    int   cur_step;
    bit   busy_hist [MAXSTEP];
    logic last_busy;
    int   tp_count;
    int   tp_step;

    int         log_id   [MAXLOG];
    logic [7:0] log_data [MAXLOG];
    bit         log_last [MAXLOG];
    int         log_step [MAXLOG];
    int         log_n;

    int         exp_id   [MAXLOG];
    logic [7:0] exp_data [MAXLOG];
    bit         exp_last [MAXLOG];
    int         exp_n;
    int         model_last;

    task automatic load_byte(input int r, input logic [7:0] d, input bit l);
        if (buf_len[r] < MAXB) begin
            buf_data[r][buf_len[r]] = d;
            buf_last[r][buf_len[r]] = l;
            buf_len[r]++;
        end
    endtask

    task automatic load_msg(input int r, input int len);
        for (int b = 0; b < len; b++) load_byte(r, 8'($urandom), b == len - 1);
    endtask

    task automatic clear_bufs();
        for (int r = 0; r < NUM_REQ; r++) begin
            buf_len[r] = 0;
            buf_pos[r] = 0;
        end
    endtask

    function automatic bit drained();
        for (int r = 0; r < NUM_REQ; r++) if (buf_pos[r] < buf_len[r]) return 1'b0;
        return 1'b1;
    endfunction

    // Whole-message round robin: next owner is the first requester after the
    // previous owner that still has bytes; its message goes out unbroken.
    task automatic build_expected();
        int pos [NUM_REQ];
        int pick;
        bit more;
        for (int r = 0; r < NUM_REQ; r++) pos[r] = buf_pos[r];
        exp_n = 0;
        more  = 1'b1;
        while (more) begin
            pick = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                int c;
                c = (model_last + k) % NUM_REQ;
                if (pick < 0 && pos[c] < buf_len[c]) pick = c;
            end
            if (pick < 0) begin
                more = 1'b0;
            end else begin
                model_last = pick;
                do begin
                    exp_id[exp_n]   = pick;
                    exp_data[exp_n] = buf_data[pick][pos[pick]];
                    exp_last[exp_n] = buf_last[pick][pos[pick]];
                    exp_n++;
                    pos[pick]++;
                end while (!exp_last[exp_n-1] && pos[pick] < buf_len[pick]);
            end
        end
    endtask

    // One clock: drive at negedge, sample 1 ns later, commit at posedge.
    task automatic step();
        int idx;
        int adv_cnt;
        bit hs;
        bit adv [NUM_REQ];
        logic [NUM_REQ-1:0] exp_rdy;
        @(negedge clk);
        for (int r = 0; r < NUM_REQ; r++) begin
            if (buf_pos[r] < buf_len[r]) begin
                req_valid[r]                = 1'b1;
                req_data[r*WIDTH +: WIDTH]  = buf_data[r][buf_pos[r]];
                req_last[r]                 = buf_last[r][buf_pos[r]];
            end else begin
                req_valid[r]                = 1'b0;
                req_data[r*WIDTH +: WIDTH]  = 8'($urandom);
                req_last[r]                 = 1'($urandom);
            end
        end
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (cur_step % 2 == 0);
            default: tx_ready = ($urandom_range(0, 3) != 0);
        endcase
        #1;
        idx = cur_step;
        cur_step++;
        if (idx < MAXSTEP) busy_hist[idx] = (busy === 1'b1);
        last_busy = busy;
        if (timeout_pulse === 1'b1) begin
            tp_count++;
            tp_step = idx;
        end
        checks++;
        if ($countones(req_ready) > 1) begin
            errors++;
            $display("FAIL ready_onehot step %0d: req_ready=%b, required at most one bit", idx, req_ready);
        end
        if (busy !== 1'b1) begin
            checks++;
            if (tx_valid !== 1'b0 || req_ready !== '0 || tx_data !== '0) begin
                errors++;
                $display("FAIL idle_outputs step %0d: tx_valid=%b req_ready=%b tx_data=%h, required all 0",
                         idx, tx_valid, req_ready, tx_data);
            end
        end else if (tx_valid === 1'b1) begin
            exp_rdy = '0;
            exp_rdy[grant_id] = tx_ready;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL ready_mirror step %0d: req_ready=%b, required %b", idx, req_ready, exp_rdy);
            end
        end
        hs = (tx_valid === 1'b1) && (tx_ready === 1'b1);
        adv_cnt = 0;
        for (int r = 0; r < NUM_REQ; r++) begin
            adv[r] = (req_valid[r] === 1'b1) && (req_ready[r] === 1'b1);
            if (adv[r]) adv_cnt++;
        end
        checks++;
        if (adv_cnt != (hs ? 1 : 0)) begin
            errors++;
            $display("FAIL handshake_pair step %0d: requester handshakes=%0d, required %0d", idx, adv_cnt, hs ? 1 : 0);
        end
        if (hs && log_n < MAXLOG) begin
            log_id[log_n]   = int'(grant_id);
            log_data[log_n] = tx_data;
            log_last[log_n] = req_last[grant_id];
            log_step[log_n] = idx;
            log_n++;
            $display("tx step %0d: req %0d byte 0x%02h last %0b", idx, grant_id, tx_data, req_last[grant_id]);
        end
        @(posedge clk);
        for (int r = 0; r < NUM_REQ; r++) if (adv[r]) buf_pos[r]++;
    endtask

    task automatic wait_log(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (log_n < target && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (log_n < target) begin
            errors++;
            $display("FAIL %s: got %0d bytes after %0d cycles, required %0d", name, log_n, budget, target);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(drained() && last_busy === 1'b0) && n < budget);
        checks++;
        if (!(drained() && last_busy === 1'b0)) begin
            errors++;
            $display("FAIL %s: not idle after %0d cycles, required drained and busy=0", name, budget);
        end
    endtask

    task automatic run_scenario(input string name, input int budget);
        build_expected();
        log_n = 0;
        wait_idle(budget, {name, "_budget"});
        checks++;
        if (log_n != exp_n) begin
            errors++;
            $display("FAIL %s_count: got %0d bytes, required %0d", name, log_n, exp_n);
        end
        for (int k = 0; k < log_n && k < exp_n; k++) begin
            checks++;
            if (log_id[k] != exp_id[k] || log_data[k] !== exp_data[k] || log_last[k] != exp_last[k]) begin
                errors++;
                $display("FAIL %s_byte %0d: got req %0d data %02h last %0b, required req %0d data %02h last %0b",
                         name, k, log_id[k], log_data[k], log_last[k], exp_id[k], exp_data[k], exp_last[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        req_last  = '0;
        req_data  = NUM_REQ*WIDTH'($urandom);
        tx_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b, required 0", tx_valid); end
        checks++;
        if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b, required 0", req_ready); end
        checks++;
        if (grant_id !== '0) begin errors++; $display("FAIL reset_grant_id: got %0d, required 0", grant_id); end
        checks++;
        if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL reset_timeout_pulse: got %b, required 0", timeout_pulse); end
        checks++;
        if (tx_data !== '0) begin errors++; $display("FAIL reset_tx_data: got %h, required 0", tx_data); end
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_contention();
        int want;
        ready_mode = 0;
        clear_bufs();
        for (int rnd = 0; rnd < 4; rnd++) begin
            load_msg(0, 3);
            load_msg(1, 3);
        end
        run_scenario("contention", 400);
        // Bytes of a message are back to back; messages are GAP idle cycles plus one grant cycle apart.
        for (int k = 1; k < log_n; k++) begin
            want = log_last[k-1] ? GAP + 2 : 1;
            checks++;
            if (log_step[k] - log_step[k-1] != want) begin
                errors++;
                $display("FAIL contention_spacing %0d: got %0d cycles, required %0d", k, log_step[k] - log_step[k-1], want);
            end
        end
    endtask

    task automatic test_single();
        int s;
        ready_mode = 0;
        clear_bufs();
        load_byte(0, 8'h48, 1'b0);
        load_byte(0, 8'h49, 1'b1);
        s = cur_step;
        run_scenario("single", 100);
        checks++;
        if (log_step[0] != s + 1 || log_step[1] != s + 2) begin
            errors++;
            $display("FAIL single_latency: got steps %0d,%0d, required %0d,%0d", log_step[0], log_step[1], s + 1, s + 2);
        end
        checks++;
        if (busy_hist[s] != 1'b0) begin errors++; $display("FAIL single_busy_before: got 1, required 0"); end
        for (int j = s + 1; j <= s + 2 + GAP; j++) begin
            checks++;
            if (busy_hist[j] != 1'b1) begin
                errors++;
                $display("FAIL single_busy step %0d: got 0, required 1", j);
            end
        end
        checks++;
        if (busy_hist[s + 3 + GAP] != 1'b0) begin errors++; $display("FAIL single_busy_after: got 1, required 0"); end
    endtask

    task automatic test_backpressure();
        ready_mode = 1;
        clear_bufs();
        load_msg($urandom_range(0, NUM_REQ - 1), 4);
        run_scenario("backpressure", 200);
    endtask

    task automatic test_random();
        ready_mode = 2;
        for (int it = 0; it < 4; it++) begin
            clear_bufs();
            for (int r = 0; r < NUM_REQ; r++) begin
                int nmsg;
                nmsg = $urandom_range(0, 3);
                for (int m = 0; m < nmsg; m++) load_msg(r, $urandom_range(1, 4));
            end
            run_scenario("random", 3000);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] d0, d1, d2;
        int stall;
        int h;
        ready_mode = 0;
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        // Stall shorter than the limit: the message must survive.
        clear_bufs();
        log_n = 0;
        tp_count = 0;
        load_byte(0, d0, 1'b0);
        wait_log(1, 10, "short_stall_first");
        stall = $urandom_range(1, TMO - 2);
        repeat (stall) step();
        load_byte(0, d1, 1'b1);
        wait_idle(60, "short_stall_idle");
        model_last = 0;
        checks++;
        if (tp_count != 0) begin errors++; $display("FAIL short_stall_pulse: got %0d pulses, required 0", tp_count); end
        checks++;
        if (log_n != 2 || log_data[1] !== d1 || log_last[1] != 1'b1) begin
            errors++;
            $display("FAIL short_stall_msg: got %0d bytes second %02h, required 2 bytes second %02h", log_n, log_data[1], d1);
        end
        // Owner never finishes: grant revoked TMO cycles after its last byte.
        clear_bufs();
        log_n = 0;
        tp_count = 0;
        load_byte(1, d2, 1'b0);
        wait_log(1, 10, "timeout_first");
        h = log_step[0];
        wait_idle(60, "timeout_idle");
        model_last = 1;
        checks++;
        if (log_id[0] != 1 || log_data[0] !== d2) begin
            errors++;
            $display("FAIL timeout_byte: got req %0d data %02h, required req 1 data %02h", log_id[0], log_data[0], d2);
        end
        checks++;
        if (tp_count != 1 || tp_step != h + TMO + 1) begin
            errors++;
            $display("FAIL timeout_pulse: got %0d pulses at step %0d, required 1 at step %0d", tp_count, tp_step, h + TMO + 1);
        end
        checks++;
        if (busy_hist[h + TMO + 1] != 1'b1 || busy_hist[h + TMO + GAP] != 1'b1) begin
            errors++;
            $display("FAIL timeout_gap: got busy %0b/%0b, required 1/1", busy_hist[h + TMO + 1], busy_hist[h + TMO + GAP]);
        end
        checks++;
        if (busy_hist[h + TMO + GAP + 1] != 1'b0) begin
            errors++;
            $display("FAIL timeout_idle_after: got busy 1, required 0");
        end
    endtask

    task automatic test_reset_mid();
        ready_mode = 0;
        clear_bufs();
        log_n = 0;
        load_msg(0, 5);
        wait_log(2, 10, "reset_mid_bytes");
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || req_ready !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: got tx_valid=%b req_ready=%b busy=%b, required all 0", tx_valid, req_ready, busy);
        end
        clear_bufs();
        for (int r = 0; r < NUM_REQ; r++) load_msg(r, 2);
        log_n = 0;
        repeat (3) step();
        checks++;
        if (log_n != 0 || !(buf_pos[0] == 0 && buf_pos[1] == 0 && buf_pos[2] == 0)) begin
            errors++;
            $display("FAIL reset_mid_hold: got %0d handshakes in reset, required 0", log_n);
        end
        #2 rst_n = 1'b1;
        model_last = NUM_REQ - 1;
        run_scenario("after_reset", 300);
        checks++;
        if (log_n < 1 || log_id[0] != 0) begin
            errors++;
            $display("FAIL after_reset_first: got req %0d (%0d bytes), required req 0", log_id[0], log_n);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        tx_ready   = 1'b0;
        ready_mode = 0;
        cur_step   = 0;
        log_n      = 0;
        exp_n      = 0;
        tp_count   = 0;
        tp_step    = -1;
        last_busy  = 1'b0;
        model_last = NUM_REQ - 1;
        test_reset();
        test_contention();
        test_single();
        test_backpressure();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters sharing one uart_transmitter (legal 2..8).
REQ-002 Parameter WIDTH, default 8: byte width of every data path.
REQ-003 Parameter GAP_CYCLES, default 16: idle clk cycles inserted after each message (0 = no gap).
REQ-004 Parameter TIMEOUT, default 1_250_000: cycles a granted requester may hold valid low mid-message before the grant is revoked (0 = never revoke).
REQ-005 clk  input  1  single clock; all state on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req_data  input  NUM_REQ*WIDTH  per-requester byte; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 req_valid  input  NUM_REQ  per-requester byte valid.
REQ-009 req_last  input  NUM_REQ  marks the final byte of a message; sampled with req_data.
REQ-010 req_ready  output  NUM_REQ  per-requester ready; at most one bit high in any cycle.
REQ-011 tx_data  output  WIDTH  byte to uart_transmitter data_in.
REQ-012 tx_valid  output  1  to uart_transmitter data_in_valid.
REQ-013 tx_ready  input  1  from uart_transmitter data_in_ready.
REQ-014 grant_id  output  $clog2(NUM_REQ)  index of current owner; valid while busy=1.
REQ-015 busy  output  1  high in LOCK and GAP states.
REQ-016 timeout_pulse  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-017 FSM states: IDLE, LOCK, GAP.
REQ-018 IDLE: if any req_valid is high, grant the first requester with valid high, searching round-robin from rr_ptr+1 modulo NUM_REQ; register grant_id, load rr_ptr with the granted index, go to LOCK.
REQ-019 Grant latency: with tx_ready high, the first byte handshakes on tx exactly one cycle after req_valid is first sampled high in IDLE.
REQ-020 LOCK: tx_data=req_data[grant_id], tx_valid=req_valid[grant_id], req_ready[grant_id]=tx_ready; all other req_ready bits 0. This path is combinational and has zero added latency.
REQ-021 Outside LOCK: tx_valid=0, req_ready=0, tx_data=0.
REQ-022 Handshake = tx_valid & tx_ready in LOCK; a handshake with req_last[grant_id]=1 ends the message: go to GAP, or to IDLE if GAP_CYCLES=0.
REQ-023 Grant is held for the whole message: valid from other requesters never preempts it, and a byte without last keeps LOCK.
REQ-024 Timeout counter clears on every handshake and whenever req_valid[grant_id]=1; it increments otherwise in LOCK. On reaching TIMEOUT (when TIMEOUT>0): pulse timeout_pulse, go to GAP.
REQ-025 GAP: counter counts GAP_CYCLES cycles, then go to IDLE; requests are ignored during GAP.
REQ-026 Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0,...
REQ-027 A single requester that is continuously valid is re-granted after GAP with no starvation penalty.
REQ-028 Counter widths are sized by $clog2 of the respective parameter plus 1; counters never wrap.

Reset
REQ-029 While rst_n=0: state=IDLE, rr_ptr=NUM_REQ-1 (requester 0 wins first), grant_id=0, counters=0, busy=0, timeout_pulse=0, tx_valid=0, req_ready=0.
REQ-030 Reset asserted mid-message aborts it immediately with no further handshakes; the partial message is not resumed after reset.

Structure
REQ-031 Shared package uart_arb_pkg holds the FSM state encoding and the default GAP_CYCLES/TIMEOUT constants.
REQ-032 One sub-module, rr_pick (combinational round-robin picker: inputs valid vector and pointer; outputs index and found), is instantiated once.

Verification
REQ-033 Single message: req0 sends 0x48,0x49(last) with tx_ready=1 -> tx bytes 0x48,0x49 on consecutive cycles starting one cycle after valid; GAP for 16 cycles; busy=0 afterward.
REQ-034 Contention: req0 and req1 both valid with 3-byte messages -> req0's message is sent complete, then GAP, then req1's message complete; grants alternate over 4 rounds.
REQ-035 Backpressure: tx_ready toggles every cycle during a 4-byte message -> each byte is accepted exactly once, req_ready mirrors tx_ready, and no other req_ready bit is asserted.
REQ-036 Timeout: TIMEOUT=10; req1 sends one non-last byte, then drops valid -> timeout_pulse appears 10 cycles later, then GAP, then IDLE.
REQ-037 Reset mid-message: pull rst_n low after byte 2 of 5 -> tx_valid=0 asynchronously; after release, req0 is granted first.
